pm_entry_responder: RTL and testbench

PM_ENTRY_RESPONDER -- requirements
Module: pm_entry_responder

---
 rtl/pm_entry_responder_if.sv | 25 ++
 rtl/pm_entry_responder.sv | 167 ++++++++++++++++
 tb/tb_pm_entry_responder.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pm_entry_responder_if.sv
// Sideband message channel between the PM entry responder and the sideband block.
// The partner's message and the acceptance of our response arrive here; our response leaves here.
interface pm_entry_responder_if;
   logic       i_msg_valid;
   logic [3:0] i_msg_no;
   logic       i_msg_done;
   logic       o_msg_valid;
   logic [3:0] o_msg_no;

   modport slave (
      input  i_msg_valid,
      input  i_msg_no,
      input  i_msg_done,
      output o_msg_valid,
      output o_msg_no
   );

   modport master (
      output i_msg_valid,
      output i_msg_no,
      output i_msg_done,
      input  o_msg_valid,
      input  o_msg_no
   );
endinterface

// File: rtl/pm_entry_responder.sv
// Answers a partner's L1/L2 PM entry request once the local RDI FSM is ready,
// or with PMNAK on a request mismatch or a local-ready timeout.
module pm_entry_responder #(
   parameter int TIMEOUT_US = 1,
   parameter int CNT_W      = 13
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic                  i_req_L1_or_L2,
   input  logic [1:0]            i_clk_sel,
   input  logic                  i_force_exit,
   pm_entry_responder_if.slave   sb,
   output logic                  o_test_done,
   output logic                  o_pm_nak,
   output logic                  o_timeout,
   output logic                  o_req_type
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_LOCAL = 2'd1,
      SEND_RSP   = 2'd2,
      DONE       = 2'd3
   } state_t;

   localparam logic [3:0] MSG_REQ_L1    = 4'd2;
   localparam logic [3:0] MSG_REQ_L2    = 4'd3;
   localparam logic [3:0] MSG_RSP_PMNAK = 4'd9;
   localparam logic [3:0] MSG_RSP_L1    = 4'd10;
   localparam logic [3:0] MSG_RSP_L2    = 4'd11;

   // Last legal counter value in WAIT_LOCAL: TIMEOUT_US microseconds at the latched clock rate.
   function automatic logic [CNT_W-1:0] limit_m1(input logic [1:0] sel);
      int lim;
      lim = (TIMEOUT_US * 100) << sel;
      return CNT_W'(lim - 1);
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             req_type_q, req_type_d;
   logic             msg_valid_q, msg_valid_d;
   logic [3:0]       msg_no_q, msg_no_d;
   logic             test_done_q, test_done_d;
   logic             pm_nak_q, pm_nak_d;
   logic             timeout_q, timeout_d;

   logic             rx_req;
   logic             rx_nak;

   assign rx_req = sb.i_msg_valid &&
                   ((sb.i_msg_no == MSG_REQ_L1) || (sb.i_msg_no == MSG_REQ_L2));
   assign rx_nak = sb.i_msg_valid && (sb.i_msg_no == MSG_RSP_PMNAK);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sel_q       <= '0;
         req_type_q  <= 1'b0;
         msg_valid_q <= 1'b0;
         msg_no_q    <= '0;
         test_done_q <= 1'b0;
         pm_nak_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         req_type_q  <= req_type_d;
         msg_valid_q <= msg_valid_d;
         msg_no_q    <= msg_no_d;
         test_done_q <= test_done_d;
         pm_nak_q    <= pm_nak_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      req_type_d  = req_type_q;
      msg_valid_d = msg_valid_q;
      msg_no_d    = msg_no_q;
      test_done_d = test_done_q;
      pm_nak_d    = pm_nak_q;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (rx_req) begin
               state_d    = WAIT_LOCAL;
               req_type_d = sb.i_msg_no[0];
               sel_d      = i_clk_sel;
               cnt_d      = '0;
            end
         end

         // Priority: force exit, partner PMNAK, local ready, then timeout.
         WAIT_LOCAL: begin
            if (i_force_exit) begin
               state_d     = DONE;
               test_done_d = 1'b1;
               pm_nak_d    = 1'b1;
            end else if (rx_nak) begin
               state_d     = DONE;
               test_done_d = 1'b1;
               pm_nak_d    = 1'b1;
            end else if (i_en) begin
               state_d     = SEND_RSP;
               msg_valid_d = 1'b1;
               if (i_req_L1_or_L2 == req_type_q)
                  msg_no_d = req_type_q ? MSG_RSP_L2 : MSG_RSP_L1;
               else
                  msg_no_d = MSG_RSP_PMNAK;
            end else if (cnt_q == limit_m1(sel_q)) begin
               state_d     = SEND_RSP;
               msg_valid_d = 1'b1;
               msg_no_d    = MSG_RSP_PMNAK;
               timeout_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         SEND_RSP: begin
            if (i_force_exit) begin
               state_d     = DONE;
               msg_valid_d = 1'b0;
               test_done_d = 1'b1;
               pm_nak_d    = 1'b1;
            end else if (sb.i_msg_done) begin
               state_d     = DONE;
               msg_valid_d = 1'b0;
               test_done_d = 1'b1;
               pm_nak_d    = (msg_no_q == MSG_RSP_PMNAK);
            end
         end

         // A NAK outcome leaves after one cycle; a granted entry waits for the local side to drop i_en.
         DONE: begin
            if (pm_nak_q || !i_en) begin
               state_d     = IDLE;
               msg_no_d    = '0;
               test_done_d = 1'b0;
               pm_nak_d    = 1'b0;
               cnt_d       = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sb.o_msg_valid = msg_valid_q;
   assign sb.o_msg_no    = msg_no_q;
   assign o_test_done    = test_done_q;
   assign o_pm_nak       = pm_nak_q;
   assign o_timeout      = timeout_q;
   assign o_req_type     = req_type_q;

endmodule

// File: tb/tb_pm_entry_responder.sv
// Directed bench for pm_entry_responder with hand-computed expectations (TIMEOUT_US = 1).
module tb_pm_entry_responder;

   logic       i_clk = 1'b0;
   logic       i_rst;
   logic       i_en;
   logic       i_req_L1_or_L2;
   logic [1:0] i_clk_sel;
   logic       i_force_exit;
   logic       o_test_done;
   logic       o_pm_nak;
   logic       o_timeout;
   logic       o_req_type;

   int n_assert = 0;
   int n_fail   = 0;

   pm_entry_responder_if sb ();

   pm_entry_responder #(
      .TIMEOUT_US (1),
      .CNT_W      (13)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_en           (i_en),
      .i_req_L1_or_L2 (i_req_L1_or_L2),
      .i_clk_sel      (i_clk_sel),
      .i_force_exit   (i_force_exit),
      .sb             (sb),
      .o_test_done    (o_test_done),
      .o_pm_nak       (o_pm_nak),
      .o_timeout      (o_timeout),
      .o_req_type     (o_req_type)
   );

   always #5 i_clk = ~i_clk;

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic cycn(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_msg(input logic [3:0] no);
      sb.i_msg_valid = 1'b1;
      sb.i_msg_no    = no;
      cyc();
      sb.i_msg_valid = 1'b0;
      sb.i_msg_no    = 4'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100us");
      $fatal(1);
   end

   initial begin
      i_rst          = 1'b1;
      i_en           = 1'b0;
      i_req_L1_or_L2 = 1'b0;
      i_clk_sel      = 2'd0;
      i_force_exit   = 1'b0;
      sb.i_msg_valid = 1'b0;
      sb.i_msg_no    = 4'd0;
      sb.i_msg_done  = 1'b0;
      cycn(2);
      chk("rst_msg_valid", sb.o_msg_valid, 0);
      chk("rst_msg_no",    sb.o_msg_no,    0);
      chk("rst_test_done", o_test_done,    0);
      chk("rst_pm_nak",    o_pm_nak,       0);
      chk("rst_timeout",   o_timeout,      0);
      chk("rst_req_type",  o_req_type,     0);
      i_rst = 1'b0;
      cyc();

      // Non-request codes and force exit are ignored in IDLE
      i_en         = 1'b1;
      i_force_exit = 1'b1;
      send_msg(4'd10);
      send_msg(4'd9);
      cycn(2);
      chk("idle_ignore_valid", sb.o_msg_valid, 0);
      chk("idle_ignore_done",  o_test_done,    0);
      chk("idle_ignore_nak",   o_pm_nak,       0);
      i_en         = 1'b0;
      i_force_exit = 1'b0;

      // Req_L1, local ready for L1 at cycle 5 -> Rsp_L1
      i_clk_sel = 2'd0;
      send_msg(4'd2);
      chk("a_req_type", o_req_type, 0);
      cycn(4);
      chk("a_wait_valid", sb.o_msg_valid, 0);
      i_en = 1'b1; i_req_L1_or_L2 = 1'b0;
      cyc();
      chk("a_send_valid", sb.o_msg_valid, 1);
      chk("a_send_no",    sb.o_msg_no,    10);
      cycn(2);
      chk("a_hold_valid", sb.o_msg_valid, 1);
      sb.i_msg_done = 1'b1;
      cyc();
      sb.i_msg_done = 1'b0;
      chk("a_done_valid", sb.o_msg_valid, 0);
      chk("a_done_td",    o_test_done,    1);
      chk("a_done_nak",   o_pm_nak,       0);
      chk("a_done_no",    sb.o_msg_no,    10);
      cyc();
      chk("a_done_hold",  o_test_done,    1);
      i_en = 1'b0;
      cyc();
      chk("a_idle_td", o_test_done, 0);
      chk("a_idle_no", sb.o_msg_no, 0);

      // Req_L2 at 200MHz, local never ready -> timeout after 200 cycles; later clk_sel change ignored
      i_clk_sel = 2'd1;
      send_msg(4'd3);
      chk("b_req_type", o_req_type, 1);
      i_clk_sel = 2'd3;
      cycn(199);
      chk("b_pre_valid",   sb.o_msg_valid, 0);
      chk("b_pre_timeout", o_timeout,      0);
      cyc();
      chk("b_timeout",   o_timeout,      1);
      chk("b_to_valid",  sb.o_msg_valid, 1);
      chk("b_to_no",     sb.o_msg_no,    9);
      cyc();
      chk("b_timeout_pulse", o_timeout, 0);
      sb.i_msg_done = 1'b1;
      i_en = 1'b1;
      cyc();
      sb.i_msg_done = 1'b0;
      chk("b_done_td",  o_test_done, 1);
      chk("b_done_nak", o_pm_nak,    1);
      cyc();
      chk("b_idle_td",  o_test_done, 0);
      chk("b_idle_nak", o_pm_nak,    0);
      i_en = 1'b0;
      cyc();

      // Req_L2 but local wants L1 -> PMNAK
      i_clk_sel = 2'd0;
      send_msg(4'd3);
      i_en = 1'b1; i_req_L1_or_L2 = 1'b0;
      cyc();
      chk("c_send_no", sb.o_msg_no, 9);
      sb.i_msg_done = 1'b1;
      cyc();
      sb.i_msg_done = 1'b0;
      i_en = 1'b0;
      chk("c_done_nak", o_pm_nak,    1);
      chk("c_done_td",  o_test_done, 1);
      cyc();
      chk("c_idle_td", o_test_done, 0);

      // Req_L2, extra Req_L1 ignored, local ready exactly at counter L-1 -> Rsp_L2 without timeout
      send_msg(4'd3);
      cycn(9);
      send_msg(4'd2);
      chk("d_req_type_kept", o_req_type, 1);
      cycn(89);
      chk("d_pre_valid", sb.o_msg_valid, 0);
      i_en = 1'b1; i_req_L1_or_L2 = 1'b1;
      cyc();
      chk("d_send_valid", sb.o_msg_valid, 1);
      chk("d_send_no",    sb.o_msg_no,    11);
      chk("d_no_timeout", o_timeout,      0);
      sb.i_msg_done = 1'b1;
      cyc();
      sb.i_msg_done = 1'b0;
      chk("d_done_nak", o_pm_nak, 0);
      cyc();
      chk("d_done_hold", o_test_done, 1);
      i_en = 1'b0;
      cyc();
      chk("d_idle_td", o_test_done, 0);

      // Force exit during SEND_RSP
      send_msg(4'd2);
      i_en = 1'b1; i_req_L1_or_L2 = 1'b0;
      cyc();
      chk("e_send_valid", sb.o_msg_valid, 1);
      i_force_exit = 1'b1;
      cyc();
      i_force_exit = 1'b0;
      chk("e_fx_valid", sb.o_msg_valid, 0);
      chk("e_fx_td",    o_test_done,    1);
      chk("e_fx_nak",   o_pm_nak,       1);
      cyc();
      chk("e_idle_td", o_test_done, 0);
      chk("e_idle_no", sb.o_msg_no,  0);
      i_en = 1'b0;

      // Partner PMNAK in WAIT_LOCAL beats a simultaneous local ready
      send_msg(4'd2);
      cycn(3);
      i_en = 1'b1;
      send_msg(4'd9);
      i_en = 1'b0;
      chk("f_nak_valid", sb.o_msg_valid, 0);
      chk("f_nak_td",    o_test_done,    1);
      chk("f_nak_nak",   o_pm_nak,       1);
      cyc();
      chk("f_idle_td", o_test_done, 0);

      // Asynchronous reset in the middle of SEND_RSP, then a fresh request
      send_msg(4'd3);
      i_en = 1'b1; i_req_L1_or_L2 = 1'b1;
      cyc();
      chk("g_send_valid", sb.o_msg_valid, 1);
      #2 i_rst = 1'b1;
      #1;
      chk("g_rst_valid",    sb.o_msg_valid, 0);
      chk("g_rst_no",       sb.o_msg_no,    0);
      chk("g_rst_req_type", o_req_type,     0);
      cyc();
      i_rst = 1'b0;
      cycn(2);
      chk("g_post_valid", sb.o_msg_valid, 0);
      i_en = 1'b0;
      send_msg(4'd2);
      i_en = 1'b1; i_req_L1_or_L2 = 1'b0;
      cyc();
      chk("g_restart_valid", sb.o_msg_valid, 1);
      chk("g_restart_no",    sb.o_msg_no,    10);
      i_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
